// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack ALU and its RPN sequencer: ALU opcodes,
// sequencer error codes and sequencer FSM states.
package stack_alu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    typedef enum logic [2:0] {
        ERR_OK         = 3'd0,
        ERR_UNDERFLOW  = 3'd1,
        ERR_FULL       = 3'd2,
        ERR_ILLEGAL_OP = 3'd3,
        ERR_BAD_DEPTH  = 3'd4
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_POP     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESULT  = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_FLUSH   = 3'd6
    } state_e;

    // Only the two binary arithmetic commands may arrive as operator tokens.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/rpn_depth_tracker.sv
// Mirror of the ALU stack occupancy; saturates at both ends so it never wraps
// and provides the predicates the sequencer needs for its legality checks.
module rpn_depth_tracker #(
    parameter int STACK_SIZE = 64,
    localparam int DEPTH_W = $clog2(STACK_SIZE + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               dec,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty,
    output logic               lt2,
    output logic               is_one
);

    logic [DEPTH_W-1:0] depth_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else if (inc && !dec && !full) begin
            depth_q <= depth_q + DEPTH_W'(1);
        end else if (dec && !inc && !empty) begin
            depth_q <= depth_q - DEPTH_W'(1);
        end
    end

    assign depth  = depth_q;
    assign full   = (depth_q == DEPTH_W'(STACK_SIZE));
    assign empty  = (depth_q == '0);
    assign lt2    = (depth_q < DEPTH_W'(2));
    assign is_one = (depth_q == DEPTH_W'(1));

endmodule

// File: rtl/rpn_sequencer.sv
// Drives the stack ALU from a stream of reverse-Polish tokens and returns the
// final stack value with overflow and error status on a result interface.
module rpn_sequencer
    import stack_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STACK_SIZE = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             tok_valid,
    output logic                             tok_ready,
    input  logic                             tok_is_op,
    input  logic [DATA_WIDTH-1:0]            tok_data,
    input  logic                             tok_last,
    output logic [2:0]                       alu_opcode,
    output logic [DATA_WIDTH-1:0]            alu_data,
    input  logic [DATA_WIDTH-1:0]            alu_result,
    input  logic                             alu_overflow,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [DATA_WIDTH-1:0]            res_data,
    output logic                             res_overflow,
    output logic [2:0]                       res_err,
    output logic [$clog2(STACK_SIZE+1)-1:0]  depth,
    output logic [2:0]                       dbg_state
);

    // Both interfaces: a transfer happens on a rising edge where valid && ready;
    // the producer holds its payload stable while valid is high and not accepted.

    state_e                  state_q, state_d;
    err_e                    err_q, tok_err;
    logic                    run_q;
    logic [DATA_WIDTH-1:0]   tok_data_q, res_data_q;
    logic                    tok_op_q, tok_last_q;
    logic                    ovf_pend_q, sticky_ovf_q;
    logic                    tok_accept;
    logic                    dt_inc, dt_dec, dt_full, dt_empty, dt_lt2, dt_one;

    rpn_depth_tracker #(.STACK_SIZE(STACK_SIZE)) u_depth (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (dt_inc),
        .dec    (dt_dec),
        .depth  (depth),
        .full   (dt_full),
        .empty  (dt_empty),
        .lt2    (dt_lt2),
        .is_one (dt_one)
    );

    assign tok_accept = tok_valid && tok_ready;

    always_comb begin
        tok_err = ERR_OK;
        if (!tok_is_op) begin
            if (dt_full) tok_err = ERR_FULL;
        end else if (!is_arith_op(tok_data[2:0])) begin
            tok_err = ERR_ILLEGAL_OP;
        end else if (dt_lt2) begin
            tok_err = ERR_UNDERFLOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tok_accept) begin
                    if (tok_err != ERR_OK) state_d = tok_last ? ST_DRAIN : ST_FLUSH;
                    else                   state_d = ST_ISSUE;
                end
            end
            ST_ISSUE:   state_d = tok_last_q ? ST_POP : ST_IDLE;
            ST_POP:     state_d = dt_one ? ST_CAPTURE : ST_DRAIN;
            ST_CAPTURE: state_d = ST_RESULT;
            ST_RESULT:  if (res_ready) state_d = ST_IDLE;
            ST_FLUSH:   if (tok_accept && tok_last) state_d = ST_DRAIN;
            ST_DRAIN:   if (dt_empty) state_d = ST_RESULT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ALU command and handshake outputs are decoded from the registered state.
    always_comb begin
        tok_ready  = 1'b0;
        alu_opcode = OP_NOP;
        alu_data   = '0;
        res_valid  = 1'b0;
        dt_inc     = 1'b0;
        dt_dec     = 1'b0;
        case (state_q)
            ST_IDLE, ST_FLUSH: tok_ready = run_q;
            ST_ISSUE: begin
                if (tok_op_q) begin
                    alu_opcode = tok_data_q[2:0];
                    dt_dec     = 1'b1;
                end else begin
                    alu_opcode = OP_PUSH;
                    alu_data   = tok_data_q;
                    dt_inc     = 1'b1;
                end
            end
            ST_POP: begin
                if (dt_one) begin
                    alu_opcode = OP_POP;
                    dt_dec     = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!dt_empty) begin
                    alu_opcode = OP_POP;
                    dt_dec     = 1'b1;
                end
            end
            ST_RESULT: res_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            tok_data_q   <= '0;
            tok_op_q     <= 1'b0;
            tok_last_q   <= 1'b0;
            ovf_pend_q   <= 1'b0;
            sticky_ovf_q <= 1'b0;
            err_q        <= ERR_OK;
            res_data_q   <= '0;
        end else begin
            run_q <= 1'b1;
            if (state_q == ST_IDLE && tok_accept) begin
                tok_data_q <= tok_data;
                tok_op_q   <= tok_is_op;
                tok_last_q <= tok_last;
                if (tok_err != ERR_OK) err_q <= tok_err;
            end
            if (state_q == ST_POP && !dt_one) err_q <= ERR_BAD_DEPTH;
            // The ALU flags overflow on the edge that executes the operator.
            ovf_pend_q <= (state_q == ST_ISSUE) && tok_op_q;
            if (state_q == ST_RESULT && res_ready) begin
                sticky_ovf_q <= 1'b0;
                err_q        <= ERR_OK;
            end else if (ovf_pend_q && alu_overflow) begin
                sticky_ovf_q <= 1'b1;
            end
            if (state_q == ST_CAPTURE) res_data_q <= alu_result;
            if (state_q == ST_DRAIN)   res_data_q <= '0;
        end
    end

    assign res_data     = res_data_q;
    assign res_overflow = sticky_ovf_q;
    assign res_err      = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench for rpn_sequencer with a behavioural stack ALU on the command
// port and a log of every ALU command issued per expression.
module tb_rpn_sequencer;
    import stack_alu_pkg::*;

    localparam int DW = 16;
    localparam int SS = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tok_valid = 1'b0;
    logic          tok_ready;
    logic          tok_is_op = 1'b0;
    logic [DW-1:0] tok_data = '0;
    logic          tok_last = 1'b0;
    logic [2:0]    alu_opcode;
    logic [DW-1:0] alu_data;
    logic [DW-1:0] alu_result;
    logic          alu_overflow;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [DW-1:0] res_data;
    logic          res_overflow;
    logic [2:0]    res_err;
    logic [6:0]    depth;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int model_err = 0;

    logic [DW+2:0] exp_q[$];
    logic [DW+2:0] act_q[$];
    logic [DW-1:0] alu_stk[$];

    typedef struct packed {
        int            n;
        logic [4:0]    is_op;
        logic [4:0][DW-1:0] d;
        logic [DW-1:0] exp_data;
        logic [2:0]    exp_err;
        logic          exp_ovf;
        int            exp_cmds;
        int            exp_pops;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    rpn_sequencer #(.DATA_WIDTH(DW), .STACK_SIZE(SS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_is_op    (tok_is_op),
        .tok_data     (tok_data),
        .tok_last     (tok_last),
        .alu_opcode   (alu_opcode),
        .alu_data     (alu_data),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_overflow (res_overflow),
        .res_err      (res_err),
        .depth        (depth),
        .dbg_state    (dbg_state)
    );

    // Behavioural stack ALU: registered result/overflow, illegal accesses counted.
    always @(posedge clk or negedge rst_n) begin
        logic [DW-1:0]   a, b;
        logic [DW:0]     s;
        logic [2*DW-1:0] p;
        if (!rst_n) begin
            alu_stk.delete();
            alu_result   <= '0;
            alu_overflow <= 1'b0;
        end else begin
            case (alu_opcode)
                OP_PUSH: begin
                    if (alu_stk.size() >= SS) model_err++;
                    else alu_stk.push_back(alu_data);
                end
                OP_ADD, OP_MUL: begin
                    if (alu_stk.size() < 2) begin
                        model_err++;
                    end else begin
                        a = alu_stk.pop_back();
                        b = alu_stk.pop_back();
                        if (alu_opcode == OP_ADD) begin
                            s = a + b;
                            alu_stk.push_back(s[DW-1:0]);
                            alu_overflow <= s[DW];
                        end else begin
                            p = a * b;
                            alu_stk.push_back(p[DW-1:0]);
                            alu_overflow <= |p[2*DW-1:DW];
                        end
                    end
                end
                OP_POP: begin
                    if (alu_stk.size() == 0) model_err++;
                    else alu_result <= alu_stk.pop_back();
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n && alu_opcode != OP_NOP) act_q.push_back({alu_opcode, alu_data});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_tok(input logic is_op, input logic [DW-1:0] d, input logic last);
        int n;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        tok_is_op = is_op;
        tok_data  = d;
        tok_last  = last;
        tok_valid = 1'b1;
        n = 0;
        while (!tok_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tok_accept", {31'd0, tok_ready}, 32'd1);
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
    endtask

    task automatic get_result(input string pfx, input logic [DW-1:0] xd,
                              input logic [2:0] xe, input logic xo);
        int n;
        @(negedge clk);
        n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({pfx, " res_valid"}, {31'd0, res_valid}, 32'd1);
        chk({pfx, " res_data"}, {16'd0, res_data}, {16'd0, xd});
        chk({pfx, " res_err"}, {29'd0, res_err}, {29'd0, xe});
        chk({pfx, " res_overflow"}, {31'd0, res_overflow}, {31'd0, xo});
        chk({pfx, " tok_ready_in_result"}, {31'd0, tok_ready}, 32'd0);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic check_tail(input string pfx, input int xcmds, input int xpops);
        int pops;
        pops = 0;
        foreach (act_q[i]) if (act_q[i][DW+2:DW] == OP_POP) pops++;
        chk({pfx, " cmd_count"}, act_q.size(), xcmds);
        chk({pfx, " pop_count"}, pops, xpops);
        chk({pfx, " alu_empty"}, alu_stk.size(), 0);
        chk({pfx, " alu_misuse"}, model_err, 0);
        chk({pfx, " depth"}, {25'd0, depth}, 32'd0);
    endtask

    function automatic vec_t mk(input int n, input logic [4:0] ops,
                                input logic [DW-1:0] t0, t1, t2, t3, t4,
                                input logic [DW-1:0] xd, input logic [2:0] xe,
                                input logic xo, input int xc, input int xp);
        vec_t v;
        v.n = n;  v.is_op = ops;
        v.d[0] = t0; v.d[1] = t1; v.d[2] = t2; v.d[3] = t3; v.d[4] = t4;
        v.exp_data = xd; v.exp_err = xe; v.exp_ovf = xo;
        v.exp_cmds = xc; v.exp_pops = xp;
        return v;
    endfunction

    task automatic run_vec(input int k);
        string pfx;
        pfx = $sformatf("vec%0d", k);
        act_q.delete();
        for (int i = 0; i < vecs[k].n; i++)
            send_tok(vecs[k].is_op[i], vecs[k].d[i], i == vecs[k].n - 1);
        get_result(pfx, vecs[k].exp_data, vecs[k].exp_err, vecs[k].exp_ovf);
        check_tail(pfx, vecs[k].exp_cmds, vecs[k].exp_pops);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(3, 5'b00100, 16'd3, 16'd2, 16'd5, 16'd0, 16'd0, 16'h0006, 3'd0, 1'b0, 4, 1);
        vecs[1] = mk(3, 5'b00100, 16'h8000, 16'd2, 16'd5, 16'd0, 16'd0, 16'h0000, 3'd0, 1'b1, 4, 1);
        vecs[2] = mk(3, 5'b00100, 16'd7, 16'd9, 16'd4, 16'd0, 16'd0, 16'h0010, 3'd0, 1'b0, 4, 1);
        vecs[3] = mk(4, 5'b01010, 16'd5, 16'd4, 16'd1, 16'd4, 16'd0, 16'h0000, 3'd1, 1'b0, 2, 1);
        vecs[4] = mk(2, 5'b00000, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'h0000, 3'd4, 1'b0, 4, 2);
        vecs[5] = mk(3, 5'b00100, 16'd4, 16'd4, 16'd3, 16'd0, 16'd0, 16'h0000, 3'd3, 1'b0, 4, 2);
        vecs[6] = mk(3, 5'b00100, 16'hFFFF, 16'd2, 16'd4, 16'd0, 16'd0, 16'h0001, 3'd0, 1'b1, 4, 1);
        vecs[7] = mk(5, 5'b11000, 16'd2, 16'd3, 16'd4, 16'd5, 16'd4, 16'h000E, 3'd0, 1'b0, 6, 1);
        vecs[8] = mk(1, 5'b00000, 16'd42, 16'd0, 16'd0, 16'd0, 16'd0, 16'h002A, 3'd0, 1'b0, 2, 1);
        vecs[9] = mk(1, 5'b00001, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'h0000, 3'd1, 1'b0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst tok_ready", {31'd0, tok_ready}, 32'd0);
        chk("rst alu_opcode", {29'd0, alu_opcode}, 32'd0);
        chk("rst alu_data", {16'd0, alu_data}, 32'd0);
        chk("rst res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst res_data", {16'd0, res_data}, 32'd0);
        chk("rst res_err", {29'd0, res_err}, 32'd0);
        chk("rst res_overflow", {31'd0, res_overflow}, 32'd0);
        chk("rst depth", {25'd0, depth}, 32'd0);
        rst_n = 1'b1;

        // Exact ALU command stream for 3*2
        act_q.delete();
        exp_q = '{19'h60003, 19'h60002, 19'h50000, 19'h70000};
        run_vec(0);
        chk("seq0 len", act_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < act_q.size()) chk($sformatf("seq0 cmd%0d", i), {13'd0, act_q[i]}, {13'd0, exp_q[i]});

        for (int k = 1; k < 10; k++) run_vec(k);

        // Stack full: 64 pushes accepted, the 65th is rejected
        act_q.delete();
        for (int i = 0; i < SS; i++) send_tok(1'b0, DW'(i + 1), 1'b0);
        repeat (2) @(negedge clk);
        chk("full depth64", {25'd0, depth}, 32'd64);
        send_tok(1'b0, 16'hBEEF, 1'b1);
        get_result("full", 16'h0000, 3'd2, 1'b0);
        check_tail("full", 2 * SS, SS);

        // Result back-pressure
        act_q.delete();
        send_tok(1'b0, 16'h0009, 1'b1);
        begin
            int n;
            n = 0;
            while (!res_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("hold c%0d", c), {res_valid, tok_ready, res_err, res_overflow, 10'd0, res_data},
                {1'b1, 1'b0, 3'd0, 1'b0, 10'd0, 16'h0009});
            @(negedge clk);
        end
        get_result("hold", 16'h0009, 3'd0, 1'b0);
        check_tail("hold", 2, 1);

        // Reset asserted while a push is being issued
        send_tok(1'b0, 16'd3, 1'b0);
        send_tok(1'b0, 16'd4, 1'b0);
        send_tok(1'b0, 16'd5, 1'b0);
        chk("mid state", {29'd0, dbg_state}, {29'd0, ST_ISSUE});
        chk("mid opcode", {29'd0, alu_opcode}, {29'd0, OP_PUSH});
        chk("mid depth", {25'd0, depth}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mrst alu_opcode", {29'd0, alu_opcode}, 32'd0);
        chk("mrst alu_data", {16'd0, alu_data}, 32'd0);
        chk("mrst tok_ready", {31'd0, tok_ready}, 32'd0);
        chk("mrst res_valid", {31'd0, res_valid}, 32'd0);
        chk("mrst res_err", {29'd0, res_err}, 32'd0);
        chk("mrst depth", {25'd0, depth}, 32'd0);
        chk("mrst state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
